// File: rtl/instr_fetch_queue_pkg.sv
// Shared fetch definitions: queue FSM encoding, end-of-trace marker and entry layout.
package instr_fetch_queue_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } fq_state_t;

  // An all-zero instruction word marks the end of the fetched trace.
  localparam logic [31:0] END_OF_TRACE = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fq_entry_t;

endpackage

// File: rtl/instr_fetch_queue_storage.sv
// Entry register file: one write port, one combinational read port, data is never reset.
module fq_storage
  import instr_fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             we,
  input  logic [PTR_W-1:0] waddr,
  input  fq_entry_t        wdata,
  input  logic [PTR_W-1:0] raddr,
  output fq_entry_t        rdata
);

  fq_entry_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue with end-of-trace drain tracking; pointers, count and FSM live here.
module instr_fetch_queue
  import instr_fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  input  logic [31:0]      in_pc,
  input  logic [31:0]      in_instr,
  output logic             in_ready,
  output logic             out_valid,
  output logic [31:0]      out_pc,
  output logic [31:0]      out_instr,
  input  logic             out_ready,
  input  logic             flush,
  output logic [PTR_W:0]   count,
  output logic             trace_done
);

  // Handshake: a word moves on a side only in a cycle where its valid and ready are
  // both high at the rising edge and flush is low; flush wins over every transfer.

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  fq_state_t        state;
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W:0]   count_next;
  logic             enq;
  logic             deq;
  logic             eot;
  fq_entry_t        wr_entry;
  fq_entry_t        rd_entry;

  assign in_ready   = (count < FULL_CNT) && (state == RUN);
  assign out_valid  = (count != '0);
  assign trace_done = (state == DONE);

  assign enq = in_valid && in_ready && !flush && (in_instr != END_OF_TRACE);
  assign deq = out_valid && out_ready && !flush;
  // The terminating zero word is consumed by the FSM, never stored.
  assign eot = (state == RUN) && in_valid && (in_instr == END_OF_TRACE) &&
               (count < FULL_CNT) && !flush;

  always_comb begin
    count_next = count + {{PTR_W{1'b0}}, enq} - {{PTR_W{1'b0}}, deq};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      state <= RUN;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      state <= RUN;
    end else begin
      if (enq) tail <= tail + PTR_W'(1);
      if (deq) head <= head + PTR_W'(1);
      count <= count_next;
      case (state)
        RUN:     if (eot) state <= (count_next == '0) ? DONE : DRAIN;
        DRAIN:   if (count_next == '0) state <= DONE;
        DONE:    state <= DONE;
        default: state <= RUN;
      endcase
    end
  end

  assign wr_entry.pc    = in_pc;
  assign wr_entry.instr = in_instr;

  fq_storage #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_storage (
    .clk   (clk),
    .we    (enq),
    .waddr (tail),
    .wdata (wr_entry),
    .raddr (head),
    .rdata (rd_entry)
  );

  assign out_pc    = rd_entry.pc;
  assign out_instr = rd_entry.instr;

endmodule
